// File: rtl/fibo_pkg.sv
// Shared types and default sizing for the Fibonacci sequence generator.
package fibo_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fibo_state_t;

  localparam int FIBO_WIDTH_DEF = 16;
  localparam int FIBO_CNT_W_DEF = 8;

endpackage

// File: rtl/fibo_gen.sv
// Fibonacci-style term generator: first term one cycle after start, one term per cycle.
// Backpressure: out_ready low freezes all state and holds the presented term stable.
module fibo_gen
  import fibo_pkg::*;
#(
  parameter int WIDTH = FIBO_WIDTH_DEF,
  parameter int CNT_W = FIBO_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] seed0,
  input  logic [WIDTH-1:0] seed1,
  input  logic [CNT_W-1:0] num_terms,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_ovf,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             overflow
);

  fibo_state_t state, state_nxt;

  logic [WIDTH-1:0] a, b;
  logic             a_ovf, b_ovf;
  logic [CNT_W-1:0] rem;
  logic [WIDTH:0]   sum;
  logic             in_run;
  logic             last;
  logic             hs;

  assign sum    = {1'b0, a} + {1'b0, b};
  assign in_run = (state == RUN);
  assign last   = (rem == CNT_W'(1));
  assign hs     = in_run && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start && (num_terms != '0)) state_nxt = RUN;
      RUN:  if (hs && last)                 state_nxt = IDLE;
      default:                              state_nxt = IDLE;
    endcase
  end

  // Outputs are forced to zero outside RUN so IDLE looks identical to reset.
  always_comb begin
    out_valid = in_run;
    out_data  = in_run ? a : '0;
    out_ovf   = in_run && a_ovf;
    out_last  = in_run && last;
    busy      = in_run;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a        <= '0;
      b        <= '0;
      a_ovf    <= 1'b0;
      b_ovf    <= 1'b0;
      rem      <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          overflow <= 1'b0;
          if (num_terms != '0) begin
            a     <= seed0;
            b     <= seed1;
            a_ovf <= 1'b0;
            b_ovf <= 1'b0;
            rem   <= num_terms;
          end else begin
            done <= 1'b1;
          end
        end
      end else if (hs) begin
        a        <= b;
        a_ovf    <= b_ovf;
        b        <= sum[WIDTH-1:0];
        // Wrap is inherited: a sum built from a wrapped operand is itself wrong.
        b_ovf    <= sum[WIDTH] | a_ovf | b_ovf;
        rem      <= rem - CNT_W'(1);
        overflow <= overflow | a_ovf;
        if (last) done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fibo_gen.sv
// Scoreboard bench for fibo_gen at WIDTH=8: directed runs with hand-computed term tables.
module tb_fibo_gen;

  logic       clk;
  logic       rst;
  logic       start;
  logic [7:0] seed0, seed1, num_terms;
  logic       out_ready;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ovf, out_last, busy, done, overflow;

  int vectors    = 0;
  int miscompares = 0;
  int done_cnt   = 0;

  logic [9:0] exp_q[$];  // {data, ovf, last}

  logic [7:0] fib01[15] = '{8'd0, 8'd1, 8'd1, 8'd2, 8'd3, 8'd5, 8'd8, 8'd13,
                            8'd21, 8'd34, 8'd55, 8'd89, 8'd144, 8'd233, 8'd121};
  logic [7:0] seq21[5]  = '{8'd2, 8'd1, 8'd3, 8'd4, 8'd7};

  fibo_gen #(.WIDTH(8), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .seed0(seed0), .seed1(seed1),
    .num_terms(num_terms), .out_ready(out_ready), .out_valid(out_valid),
    .out_data(out_data), .out_ovf(out_ovf), .out_last(out_last),
    .busy(busy), .done(done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic start_run(input logic [7:0] s0, input logic [7:0] s1, input logic [7:0] n);
    @(posedge clk); #1;
    start = 1'b1; seed0 = s0; seed1 = s1; num_terms = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 300);
    if (!done) chk(name, 32'd0, 32'd1);
  endtask

  // Monitor: pops one expected term per handshake and checks done timing every cycle.
  initial begin
    logic       pend;
    logic [9:0] e;
    pend = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0;
      end else begin
        chk("done_timing", done, pend);
        if (done) begin
          done_cnt++;
          chk("valid_at_done", out_valid, 0);
        end
        pend = (out_valid && out_ready && out_last) ||
               (start && !out_valid && num_terms == 8'd0);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_term", 32'd1, 32'd0);
          end else begin
            e = exp_q.pop_front();
            chk("term_data", out_data, e[9:2]);
            chk("term_ovf", out_ovf, e[1]);
            chk("term_last", out_last, e[0]);
          end
        end
      end
    end
  end

  initial begin
    int d0;
    rst = 1'b1; start = 1'b0; seed0 = '0; seed1 = '0; num_terms = '0; out_ready = 1'b1;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_overflow", overflow, 0);
    #10 rst = 1'b0;

    // Run 1: seeds 0/1, 10 terms, with a start pulse mid-run that must be ignored.
    for (int i = 0; i < 10; i++) exp_q.push_back({fib01[i], 1'b0, i == 9});
    d0 = done_cnt;
    start_run(8'd0, 8'd1, 8'd10);
    @(negedge clk);
    chk("busy_run1", busy, 1);
    @(posedge clk); #1;
    start = 1'b1; seed0 = 8'd99; seed1 = 8'd7; num_terms = 8'd2;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done("timeout_run1");
    chk("overflow_run1", overflow, 0);
    chk("q_empty_run1", exp_q.size(), 0);
    @(negedge clk);
    chk("done_cnt_run1", done_cnt - d0, 1);
    chk("busy_after_run1", busy, 0);

    // Run 2: 15 terms, the last one wraps (377 mod 256 = 121).
    for (int i = 0; i < 15; i++) exp_q.push_back({fib01[i], i == 14, i == 14});
    start_run(8'd0, 8'd1, 8'd15);
    wait_done("timeout_run2");
    chk("overflow_run2", overflow, 1);
    chk("q_empty_run2", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    chk("overflow_sticky", overflow, 1);

    // Run 3: zero terms - no output, one done, overflow cleared.
    d0 = done_cnt;
    start_run(8'd5, 8'd6, 8'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("zero_valid", out_valid, 0);
      chk("zero_busy", busy, 0);
    end
    chk("zero_done_cnt", done_cnt - d0, 1);
    chk("overflow_cleared", overflow, 0);

    // Run 4: seeds 2/1, stall while term 3 is presented.
    for (int i = 0; i < 5; i++) exp_q.push_back({seq21[i], 1'b0, i == 4});
    start_run(8'd2, 8'd1, 8'd5);
    @(posedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_data", out_data, 3);
      chk("stall_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_data", out_data, 3);
    wait_done("timeout_run4");
    chk("q_empty_run4", exp_q.size(), 0);

    // Run 5: reset after the 4th accepted term of a 10-term run.
    for (int i = 0; i < 10; i++) exp_q.push_back({fib01[i], 1'b0, i == 9});
    start_run(8'd0, 8'd1, 8'd10);
    repeat (4) @(posedge clk);
    #2;
    chk("pre_rst_data", out_data, 3);
    rst = 1'b1;
    #1;
    chk("arst_valid", out_valid, 0);
    chk("arst_data", out_data, 0);
    chk("arst_last", out_last, 0);
    chk("arst_busy", busy, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("no_done_after_rst", done_cnt - d0, 0);

    // Run 6: fresh start restarts from seed0.
    for (int i = 0; i < 3; i++) exp_q.push_back({fib01[i], 1'b0, i == 2});
    start_run(8'd0, 8'd1, 8'd3);
    wait_done("timeout_run6");
    chk("q_empty_run6", exp_q.size(), 0);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fibo_gen.md
# fibo_gen

Parametrised Fibonacci-style sequence generator with programmable seeds, programmable term count and a valid/ready streaming output. A single `start` request produces `num_terms` terms of the recurrence x[n+1] = x[n] + x[n-1]. Each term carries a per-term wrap flag, and a sticky overflow status is kept. The block sits as a stimulus/sequence source feeding downstream streaming logic, and replaces the fixed 5-bit free-running generator.

## Interface
- `WIDTH`, default 16: term width in bits (≥2).
- `CNT_W`, default 8: width of the term counter; up to 2^CNT_W−1 terms per run.
- `clk`, in, 1: clock; all state updates on the rising edge.
- `rst`, in, 1: reset, asynchronous, active-high.
- `start`, in, 1: run request; sampled only in IDLE.
- `seed0`, in, WIDTH: first term x[0]; sampled with `start`.
- `seed1`, in, WIDTH: second term x[1]; sampled with `start`.
- `num_terms`, in, CNT_W: number of terms to emit; sampled with `start`.
- `out_ready`, in, 1: downstream accepts the current term.
- `out_valid`, out, 1: `out_data` holds a valid term.
- `out_data`, out, WIDTH: current term.
- `out_ovf`, out, 1: current term differs from the true (unbounded) value because of wrap.
- `out_last`, out, 1: current term is the final term of the run.
- `busy`, out, 1: run in progress (state RUN).
- `done`, out, 1: one-cycle pulse when a run ends.
- `overflow`, out, 1: sticky flag; set if any emitted term had `out_ovf`=1; cleared on accepted `start`.

## Operation
- Internal registers:
  - `a`/`b`: current term and next term, WIDTH each.
  - `a_ovf`/`b_ovf`: wrap flags for `a` and `b`.
  - `rem`: remaining terms, CNT_W bits.
- States: IDLE, RUN.
- IDLE, `start`=1, `num_terms`≠0:
  - Load `a`=`seed0`, `b`=`seed1`, `a_ovf`=`b_ovf`=0, `rem`=`num_terms`.
  - Clear `overflow`.
  - Go to RUN.
- IDLE, `start`=1, `num_terms`=0:
  - Clear `overflow`.
  - Pulse `done` next cycle.
  - Stay in IDLE; no term is emitted.
- RUN outputs:
  - `out_valid`=1, `out_data`=`a`, `out_ovf`=`a_ovf`.
  - `out_last`=(`rem`==1), `busy`=1.
- RUN, on handshake (`out_valid`&&`out_ready`):
  - `a`←`b`, `a_ovf`←`b_ovf`.
  - `b`←(`a`+`b`) mod 2^WIDTH.
  - `b_ovf`←carry-out | `a_ovf` | `b_ovf`.
  - `rem`←`rem`−1.
  - `overflow`←`overflow` | `a_ovf`.
- Handshake with `out_last`=1: go to IDLE and pulse `done` in the following cycle.
- RUN, `out_ready`=0: all state frozen; `out_data`, `out_ovf` and `out_last` hold stable.
- `start` in RUN is ignored; it is neither queued nor does it restart the run.
- Arithmetic is unsigned modulo 2^WIDTH; seeds are unsigned.
- Carries into `b` beyond `a`+`b` are not tracked. The ovf flag marks "value wrapped"; it does not count wraps.

## Timing
- Reset values:
  - `out_valid`=0, `out_data`=0, `out_ovf`=0, `out_last`=0.
  - `busy`=0, `done`=0, `overflow`=0.
  - State IDLE; `a`, `b`, `rem` and the flags all 0.
- `rst` mid-run aborts immediately. No `done` pulse follows; outputs return to reset values asynchronously.
- Latency: `start` sampled at edge T gives `out_valid`=1 with `seed0` after edge T (first cycle of RUN).
- Throughput: one term per cycle while `out_ready`=1.
- A run of N terms with `out_ready` held high:
  - `out_valid` is high for exactly N cycles.
  - `done` is high in cycle N+1, relative to the first valid cycle; `out_valid`=0 in that cycle.
- A new `start` is accepted in the same cycle that `done` is high (state is IDLE). Back-to-back gap is 1 cycle.
- All outputs are registered or decoded from state/registers only; there is no combinational path from inputs to outputs.

## Structure
- Package `fibo_pkg` holds:
  - The state enum typedef (IDLE, RUN).
  - Default constants `FIBO_WIDTH_DEF`=16 and `FIBO_CNT_W_DEF`=8.
- No sub-module: the adder, counter and FSM fit in a single module.

## Test plan
- WIDTH=8, seeds 0/1, `num_terms`=10, `out_ready`=1 -> terms 0,1,1,2,3,5,8,13,21,34; `out_last` only on 34; `done` pulse one cycle later; `overflow`=0.
- WIDTH=8, seeds 0/1, `num_terms`=15 -> terms 13 and 14 are 233 (`out_ovf`=0) and 121 (`out_ovf`=1); `overflow`=1 after the run and cleared by the next accepted `start`.
- Seeds 2/1, `num_terms`=5, `out_ready` low for 3 cycles while term 3 is presented -> `out_data`=3 held stable for 4 cycles; full sequence 2,1,3,4,7.
- `num_terms`=0 with `start` -> no `out_valid`; `done` pulses once; `busy` stays 0. Also pulse `start` during RUN -> ignored and the sequence is unaffected.
- Assert `rst` after the 4th term of a 10-term run -> all outputs 0 immediately; no `done`; a fresh `start` restarts from `seed0`.
